// File: rtl/ch_unpack.sv
// Channel-burst unpacker: captures the sel=0..channels word sequence, validates ordering,
// and writes tagged words to the downstream FIFO with frame alignment and sticky status.
module ch_unpack #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          req_data,
  input  logic [2:0]    sel,
  input  logic [2:0]    channels,
  input  logic [DW-1:0] din,
  input  logic          fifo_full,
  input  logic          clear_status,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_data,
  output logic [1:0]    fifo_tag,
  output logic          overrun,
  output logic          seq_err,
  output logic [15:0]   burst_count
);

  localparam int FP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FP_W-1:0] FP_LAST = FP_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      exp_r, exp_s;
  logic [2:0]      last_r, last_s;
  logic [FP_W-1:0] frame_pos_r, frame_pos_s;
  logic            fifo_wr_r, wr_s;
  logic [DW-1:0]   fifo_data_r;
  logic [1:0]      fifo_tag_r, tag_s;
  logic            overrun_r, set_ovr_s;
  logic            seq_err_r, set_seq_s;
  logic [15:0]     burst_count_r;
  logic            count_s;
  logic            start_req_s;

  assign start_req_s = req_data && (sel == 3'd0);

  // Next-state and write decision; a burst start takes priority in every state
  always_comb begin
    state_s     = state_r;
    exp_s       = exp_r;
    last_s      = last_r;
    frame_pos_s = frame_pos_r;
    wr_s        = 1'b0;
    tag_s       = 2'b00;
    set_ovr_s   = 1'b0;
    set_seq_s   = 1'b0;
    count_s     = 1'b0;
    if (start_req_s) begin
      set_seq_s = (state_r == COLLECT);
      if (en) begin
        last_s      = channels;
        exp_s       = 3'd1;
        frame_pos_s = (frame_pos_r == FP_LAST) ? {FP_W{1'b0}} : frame_pos_r + {{(FP_W-1){1'b0}}, 1'b1};
        if (fifo_full) begin
          // Dropped ch0 word still consumes its frame slot
          set_ovr_s = 1'b1;
          state_s   = (channels == 3'd0) ? IDLE : DROP;
        end else begin
          wr_s    = 1'b1;
          tag_s   = {(frame_pos_r == {FP_W{1'b0}}), 1'b1};
          count_s = (channels == 3'd0);
          state_s = (channels == 3'd0) ? IDLE : COLLECT;
        end
      end else begin
        state_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        COLLECT: begin
          if (!req_data) begin
            set_seq_s = 1'b1;
            state_s   = IDLE;
          end else if (sel == exp_r) begin
            if (fifo_full) begin
              set_ovr_s = 1'b1;
              state_s   = DROP;
            end else begin
              wr_s = 1'b1;
              if (sel == last_r) begin
                count_s = 1'b1;
                state_s = IDLE;
              end else begin
                exp_s = exp_r + 3'd1;
              end
            end
          end else begin
            set_seq_s = 1'b1;
            state_s   = DROP;
          end
        end
        DROP:    state_s = req_data ? DROP : IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, output and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      exp_r         <= 3'd0;
      last_r        <= 3'd0;
      frame_pos_r   <= {FP_W{1'b0}};
      fifo_wr_r     <= 1'b0;
      fifo_data_r   <= {DW{1'b0}};
      fifo_tag_r    <= 2'b00;
      overrun_r     <= 1'b0;
      seq_err_r     <= 1'b0;
      burst_count_r <= 16'd0;
    end else begin
      state_r     <= state_s;
      exp_r       <= exp_s;
      last_r      <= last_s;
      frame_pos_r <= frame_pos_s;
      fifo_wr_r   <= wr_s;
      fifo_tag_r  <= tag_s;
      if (wr_s) fifo_data_r <= din;
      if (set_ovr_s) overrun_r <= 1'b1;
      else if (clear_status) overrun_r <= 1'b0;
      if (set_seq_s) seq_err_r <= 1'b1;
      else if (clear_status) seq_err_r <= 1'b0;
      if (count_s) burst_count_r <= burst_count_r + 16'd1;
    end
  end

  assign fifo_wr     = fifo_wr_r;
  assign fifo_data   = fifo_data_r;
  assign fifo_tag    = fifo_tag_r;
  assign overrun     = overrun_r;
  assign seq_err     = seq_err_r;
  assign burst_count = burst_count_r;

endmodule

// File: tb/tb_ch_unpack.sv
// Directed self-checking bench for ch_unpack (FRAME_LEN=4 so frame wrap is reachable).
module tb_ch_unpack;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n, en, req_data, fifo_full, clear_status;
  logic [2:0]    sel, channels;
  logic [DW-1:0] din;
  logic          fifo_wr, overrun, seq_err;
  logic [DW-1:0] fifo_data;
  logic [1:0]    fifo_tag;
  logic [15:0]   burst_count;

  int vectors    = 0;
  int miscompares = 0;

  ch_unpack #(.DW(DW), .FRAME_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req_data(req_data), .sel(sel),
    .channels(channels), .din(din), .fifo_full(fifo_full), .clear_status(clear_status),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_tag(fifo_tag),
    .overrun(overrun), .seq_err(seq_err), .burst_count(burst_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] s, input logic [DW-1:0] d);
    req_data = r; sel = s; din = d;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b1; req_data = 1'b0; sel = 3'd0; channels = 3'd0;
    din = '0; fifo_full = 1'b0; clear_status = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({fifo_wr, fifo_data, fifo_tag, overrun, seq_err, burst_count} !== '0) begin
      miscompares++;
      $display("FAIL reset: wr=%0b data=%h tag=%0d ovr=%0b seq=%0b cnt=%0d, all must be 0",
               fifo_wr, fifo_data, fifo_tag, overrun, seq_err, burst_count);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    channels = 3'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 16'h0010 + 16'(i));
      vectors++;
      if (fifo_wr !== 1'b1 || fifo_data !== 16'h0010 + 16'(i) || fifo_tag !== ((i == 0) ? 2'd3 : 2'd0)) begin
        miscompares++;
        $display("FAIL single[%0d]: wr=%0b data=%h tag=%0d, want 1 %h %0d",
                 i, fifo_wr, fifo_data, fifo_tag, 16'h0010 + 16'(i), (i == 0) ? 3 : 0);
      end
    end
    drive(1'b0, 3'd0, 16'h0);
    vectors++;
    if (fifo_wr !== 1'b0 || burst_count !== 16'd1 || seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: wr=%0b cnt=%0d seq=%0b, want 0 1 0", fifo_wr, burst_count, seq_err);
    end
  endtask

  task automatic test_back_to_back_frame();
    logic [1:0] et;
    do_reset();
    channels = 3'd0;
    for (int b = 1; b <= 9; b++) begin
      drive(1'b1, 3'd0, 16'(b));
      et = ((b % 4) == 1) ? 2'd3 : 2'd1;
      vectors++;
      if (fifo_wr !== 1'b1 || fifo_tag !== et || fifo_data !== 16'(b)) begin
        miscompares++;
        $display("FAIL frame[%0d]: wr=%0b tag=%0d data=%h, want 1 %0d %h", b, fifo_wr, fifo_tag, fifo_data, et, 16'(b));
      end
    end
    drive(1'b0, 3'd0, 16'h0);
    vectors++;
    if (burst_count !== 16'd9 || fifo_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_count: cnt=%0d wr=%0b, want 9 0", burst_count, fifo_wr);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    channels = 3'd2;
    drive(1'b1, 3'd0, 16'hA0);
    vectors++;
    if (fifo_wr !== 1'b1 || fifo_tag !== 2'd3) begin
      miscompares++;
      $display("FAIL ovr_ch0: wr=%0b tag=%0d, want 1 3", fifo_wr, fifo_tag);
    end
    fifo_full = 1'b1;
    drive(1'b1, 3'd1, 16'hA1);
    fifo_full = 1'b0;
    vectors++;
    if (fifo_wr !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_ch1: wr=%0b ovr=%0b, want 0 1", fifo_wr, overrun);
    end
    drive(1'b1, 3'd2, 16'hA2);
    vectors++;
    if (fifo_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_drop: wr=%0b, want 0", fifo_wr);
    end
    drive(1'b0, 3'd0, 16'h0);
    vectors++;
    if (burst_count !== 16'd0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_cnt: cnt=%0d ovr=%0b, want 0 1", burst_count, overrun);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 16'hB0 + 16'(i));
      vectors++;
      if (fifo_wr !== 1'b1 || fifo_data !== 16'hB0 + 16'(i) || fifo_tag !== ((i == 0) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL ovr_next[%0d]: wr=%0b data=%h tag=%0d, want 1 %h %0d",
                 i, fifo_wr, fifo_data, fifo_tag, 16'hB0 + 16'(i), (i == 0) ? 1 : 0);
      end
    end
    req_data = 1'b0; clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    vectors++;
    if (overrun !== 1'b0 || burst_count !== 16'd1) begin
      miscompares++;
      $display("FAIL ovr_clear: ovr=%0b cnt=%0d, want 0 1", overrun, burst_count);
    end
  endtask

  task automatic test_restart();
    do_reset();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'hC0);
    drive(1'b1, 3'd1, 16'hC1);
    drive(1'b1, 3'd0, 16'hD0);
    vectors++;
    if (seq_err !== 1'b1 || fifo_wr !== 1'b1 || fifo_tag !== 2'd1 || fifo_data !== 16'hD0) begin
      miscompares++;
      $display("FAIL restart: seq=%0b wr=%0b tag=%0d data=%h, want 1 1 1 00d0", seq_err, fifo_wr, fifo_tag, fifo_data);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 3'(i), 16'hD0 + 16'(i));
      vectors++;
      if (fifo_wr !== 1'b1 || fifo_data !== 16'hD0 + 16'(i)) begin
        miscompares++;
        $display("FAIL restart_word[%0d]: wr=%0b data=%h, want 1 %h", i, fifo_wr, fifo_data, 16'hD0 + 16'(i));
      end
    end
    drive(1'b0, 3'd0, 16'h0);
    vectors++;
    if (burst_count !== 16'd1) begin
      miscompares++;
      $display("FAIL restart_cnt: cnt=%0d, want 1", burst_count);
    end
  endtask

  task automatic test_out_of_order_and_disable();
    int writes;
    do_reset();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'hE0);
    drive(1'b1, 3'd2, 16'hE2);
    vectors++;
    if (fifo_wr !== 1'b0 || seq_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ooo: wr=%0b seq=%0b, want 0 1", fifo_wr, seq_err);
    end
    drive(1'b1, 3'd3, 16'hE3);
    drive(1'b0, 3'd0, 16'h0);
    en = 1'b0;
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 16'hF0);
      writes += int'(fifo_wr);
    end
    en = 1'b1;
    drive(1'b0, 3'd0, 16'h0);
    writes += int'(fifo_wr);
    vectors++;
    if (writes !== 0 || burst_count !== 16'd0) begin
      miscompares++;
      $display("FAIL en_off: writes=%0d cnt=%0d, want 0 0", writes, burst_count);
    end
    channels = 3'd0;
    drive(1'b1, 3'd0, 16'h55);
    vectors++;
    if (fifo_wr !== 1'b1 || fifo_tag !== 2'd1) begin
      miscompares++;
      $display("FAIL en_pos: wr=%0b tag=%0d, want 1 1", fifo_wr, fifo_tag);
    end
    req_data = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int writes;
    do_reset();
    channels = 3'd3;
    drive(1'b1, 3'd0, 16'h70);
    drive(1'b1, 3'd1, 16'h71);
    reset_n = 1'b0;
    drive(1'b1, 3'd2, 16'h72);
    reset_n = 1'b1;
    vectors++;
    if ({fifo_wr, fifo_data, fifo_tag, overrun, seq_err, burst_count} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: wr=%0b data=%h tag=%0d ovr=%0b seq=%0b cnt=%0d, all must be 0",
               fifo_wr, fifo_data, fifo_tag, overrun, seq_err, burst_count);
    end
    writes = 0;
    drive(1'b1, 3'd3, 16'h73);
    writes += int'(fifo_wr);
    drive(1'b0, 3'd0, 16'h0);
    writes += int'(fifo_wr);
    vectors++;
    if (writes !== 0 || seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_tail: writes=%0d seq=%0b, want 0 0", writes, seq_err);
    end
    drive(1'b1, 3'd0, 16'h80);
    vectors++;
    if (fifo_wr !== 1'b1 || fifo_tag !== 2'd3) begin
      miscompares++;
      $display("FAIL mid_next: wr=%0b tag=%0d, want 1 3", fifo_wr, fifo_tag);
    end
    req_data = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back_frame();
    test_overrun();
    test_restart();
    test_out_of_order_and_disable();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
